// File: rtl/arb8_pkg.sv
// Shared types and helpers for the eight-way round-robin burst arbiter.
//   arb_state_t : sequencer state (IDLE between bursts, BURST while a grant is held)
//   NUM_REQ     : number of requesters
//   SEL_W       : width of a requester index
//   rr_pick     : first valid requester in priority order starting at ptr
package arb8_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Scan ptr, ptr+1, ... ptr+7 (mod 8); the 3-bit add provides the wrap.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] valid,
                                    input logic [SEL_W-1:0]   ptr);
    pick_t            p;
    logic [SEL_W-1:0] cand;
    p = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!p.found && valid[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/arb8_rr_if.sv
// Handshake bundle between eight producers, the arbiter and one consumer.
//   req_valid/req_last/req_data_0..7 : producer beats      (into arbiter)
//   req_ready                        : per-requester accept (from arbiter)
//   out_valid/out_data/out_last      : registered output    (from arbiter)
//   out_ready                        : consumer accept      (into arbiter)
//   grant_id/busy                    : arbitration status   (from arbiter)
// slave = arbiter side, master = producer/consumer environment side.
interface arb8_rr_if
  import arb8_pkg::*;
#(
  parameter int N = 32
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] req_ready;
  logic [N-1:0]       req_data_0;
  logic [N-1:0]       req_data_1;
  logic [N-1:0]       req_data_2;
  logic [N-1:0]       req_data_3;
  logic [N-1:0]       req_data_4;
  logic [N-1:0]       req_data_5;
  logic [N-1:0]       req_data_6;
  logic [N-1:0]       req_data_7;
  logic               out_valid;
  logic [N-1:0]       out_data;
  logic               out_last;
  logic               out_ready;
  logic [SEL_W-1:0]   grant_id;
  logic               busy;

  modport slave (
    input  req_valid, req_last,
    input  req_data_0, req_data_1, req_data_2, req_data_3,
    input  req_data_4, req_data_5, req_data_6, req_data_7,
    input  out_ready,
    output req_ready, out_valid, out_data, out_last, grant_id, busy
  );

  modport master (
    output req_valid, req_last,
    output req_data_0, req_data_1, req_data_2, req_data_3,
    output req_data_4, req_data_5, req_data_6, req_data_7,
    output out_ready,
    input  req_ready, out_valid, out_data, out_last, grant_id, busy
  );

endinterface

// File: rtl/mux8.sv
// Eight-input N-bit multiplexer.
//   d0..d7 : data inputs
//   s      : select
//   y      : selected data
module mux8 #(
  parameter int N = 32
) (
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  input  logic [N-1:0] d4,
  input  logic [N-1:0] d5,
  input  logic [N-1:0] d6,
  input  logic [N-1:0] d7,
  input  logic [2:0]   s,
  output logic [N-1:0] y
);

  always_comb begin
    case (s)
      3'd0:    y = d0;
      3'd1:    y = d1;
      3'd2:    y = d2;
      3'd3:    y = d3;
      3'd4:    y = d4;
      3'd5:    y = d5;
      3'd6:    y = d6;
      default: y = d7;
    endcase
  end

endmodule

// File: rtl/arb8_rr.sv
// Round-robin burst arbiter sharing one registered N-bit output channel among
// eight requesters. A grant is chosen in IDLE and held until the granted
// requester's beat with last=1 is accepted.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : arb8_rr_if slave modport (requests, output channel, grant status)
module arb8_rr
  import arb8_pkg::*;
#(
  parameter int N = 32
) (
  input logic      clk,
  input logic      rst,
  arb8_rr_if.slave bus
);

  arb_state_t         state;
  logic [SEL_W-1:0]   ptr;
  logic               can_load;
  logic               accept;
  logic [NUM_REQ-1:0] onehot;
  logic [N-1:0]       mux_y;
  pick_t              pick;

  mux8 #(.N(N)) u_mux (
    .d0 (bus.req_data_0),
    .d1 (bus.req_data_1),
    .d2 (bus.req_data_2),
    .d3 (bus.req_data_3),
    .d4 (bus.req_data_4),
    .d5 (bus.req_data_5),
    .d6 (bus.req_data_6),
    .d7 (bus.req_data_7),
    .s  (bus.grant_id),
    .y  (mux_y)
  );

  // req_ready depends only on state, grant_id and the output register, so
  // there is no path from req_* through to req_ready or out_*.
  always_comb begin
    can_load      = !bus.out_valid || bus.out_ready;
    onehot        = NUM_REQ'(1) << bus.grant_id;
    bus.req_ready = '0;
    accept        = 1'b0;
    if (state == BURST) begin
      bus.req_ready = onehot & {NUM_REQ{can_load}};
      accept        = bus.req_valid[bus.grant_id] && can_load;
    end
    pick = rr_pick(bus.req_valid, ptr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      bus.grant_id <= '0;
      bus.busy     <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_last <= 1'b0;
    end else begin
      // Output register: load on accept, drain when free and nothing loaded,
      // otherwise hold under backpressure.
      if (can_load) begin
        bus.out_valid <= accept;
        if (accept) begin
          bus.out_data <= mux_y;
          bus.out_last <= bus.req_last[bus.grant_id];
        end
      end

      case (state)
        IDLE: begin
          if (pick.found) begin
            bus.grant_id <= pick.idx;
            bus.busy     <= 1'b1;
            state        <= BURST;
          end
        end
        BURST: begin
          if (accept && bus.req_last[bus.grant_id]) begin
            ptr      <= bus.grant_id + SEL_W'(1);
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/arb8_rr.md
# arb8_rr

Round-robin arbiter and sequencer that shares a single N-bit output channel among eight requesters. It owns the 3-bit select of an internal `mux8` datapath and drives it from a registered grant. Grants are held for whole bursts, delimited by `last`. The output channel is registered with valid/ready. The block sits between eight producer ports (e.g. bus masters or register-file write sources) and one downstream consumer.

## Interface
- `N`, 32, data width of every requester and of the output.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  8  bit i: requester i presents a beat.
- `req_last`  in  8  bit i: requester i's current beat ends its burst.
- `req_data_0` … `req_data_7`  in  N each  requester payloads.
- `req_ready`  out  8  bit i: beat from requester i accepted this cycle when `req_valid[i]` is also high.
- `out_valid`  out  1  registered output beat present.
- `out_data`  out  N  registered payload.
- `out_last`  out  1  registered last flag.
- `out_ready`  in  1  consumer accepts `out_*` this cycle.
- `grant_id`  out  3  index of the current or last granted requester.
- `busy`  out  1  high in BURST.

## Operation
- Reset (async, immediate): state=IDLE, ptr=0, grant_id=0, busy=0, req_ready=0, out_valid=0, out_data=0, out_last=0. Any in-flight beat is discarded.
- Priority order starts at ptr and goes ptr, ptr+1, …, ptr+7, all mod 8.
- IDLE
  - If any `req_valid` is high, the first valid index in priority order is registered into `grant_id`, and the state goes to BURST.
  - `req_ready` is all zero.
  - With no requests, the state stays IDLE.
- BURST
  - can_load = !out_valid || out_ready.
  - `req_ready` = one-hot(grant_id) & {8{can_load}}.
  - A beat is accepted when `req_valid[grant_id] && can_load`. On acceptance, out_data ← mux8(req_data_*, grant_id), out_last ← req_last[grant_id], out_valid ← 1.
- Output register
  - If can_load and no beat is accepted, out_valid ← 0 (the entry drains).
  - When out_valid is high and out_ready is low, out_* hold stable.
- Burst end: accepting a beat with `req_last[grant_id]=1` sets ptr ← grant_id+1 (wraps 7→0) and returns to IDLE.
- Requester drops valid mid-burst: the grant is held and bubbles are inserted. There is no timeout and no preemption.
- Non-granted requesters see `req_ready[i]=0` at all times.
- Requests arriving in BURST are only considered at the next IDLE cycle.

## Timing
- Arbitration latency: request in IDLE at cycle 0 → grant_id and busy valid from cycle 1.
  - The first beat can be accepted in cycle 1.
  - out_valid is high from cycle 2.
- Throughput is one beat per cycle within a burst when out_ready stays high.
- There is exactly one IDLE bubble cycle between bursts.
- A single-beat burst (last=1 on the first beat) occupies 2 cycles: IDLE + BURST.
- All outputs are registered except `req_ready`, which is combinational from state, grant_id, out_valid and out_ready. There is no combinational path from `req_*` to `out_*`.
- The next requester is chosen only in IDLE, so the grant_id change after a last beat is never visible within the same cycle.

## Structure
- Package `arb8_pkg`:
  - `arb_state_t` enum {IDLE, BURST}.
  - Constants NUM_REQ=8 and SEL_W=3.
  - Function `rr_pick(valid[7:0], ptr[2:0])` returning the index and found flag.
- Datapath reuses the existing `mux8` (parameter N) with s=grant_id. No new sub-module is needed.

## Test plan
- Reset mid-burst: grant to requester 3, rst pulsed while out_valid=1 → all outputs zero immediately, ptr=0; next request from 5 alone → grant_id=5.
- Fairness: all 8 valid, single-beat bursts, out_ready=1 → grants 0,1,…,7,0 in order; out_data matches each requester's payload (req_data_i = 32'hA0+i).
- Burst hold: requester 2 sends 4 beats (last on the 4th) while requester 6 is valid → out_data sequence 2's four words, then grant_id=6 after one IDLE cycle.
- Backpressure: out_ready low for 3 cycles mid-burst → out_data stable, req_ready[grant]=0 while out_valid=1; no beat is lost or duplicated.
- Wrap and bubbles: ptr=7, requesters 7 and 0 valid → 7 is granted first, then 0. Requester 7 drops valid for 2 cycles mid-burst → grant_id stays 7, out_valid deasserts after drain, burst resumes.
